// File: rtl/i2s_adc_capture.sv
// i2s_adc_capture
//   Recovers 16-bit stereo PCM from the WM8731 ADC I2S stream. BCLK, ADCLRCK
//   and ADCDAT are oversampled in iCLK_50; a frame is published only when both
//   slots carried at least WS bits, and oL/oR update together with oValid.
// Ports
//   iCLK_50       system clock, sole clock of the block
//   iRST_N        synchronous active-low reset
//   iAUD_BCLK     codec bit clock (async)
//   iAUD_ADCLRCK  codec word clock (async), 0 = left slot, 1 = right slot
//   iAUD_ADCDAT   codec serial data (async), MSB first
//   oL, oR        last complete left/right sample, two's complement
//   oValid        one-cycle pulse when oL/oR were updated
//   oLocked       high while valid frames are being received
//   oErrCnt       saturating count of discarded frames
module i2s_adc_capture #(
  parameter int WS      = 16,
  parameter int SYNC    = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic          iCLK_50,
  input  logic          iRST_N,
  input  logic          iAUD_BCLK,
  input  logic          iAUD_ADCLRCK,
  input  logic          iAUD_ADCDAT,
  output logic [WS-1:0] oL,
  output logic [WS-1:0] oR,
  output logic          oValid,
  output logic          oLocked,
  output logic [7:0]    oErrCnt
);

  typedef enum logic [1:0] {S_IDLE, S_LEFT, S_RIGHT} state_t;

  localparam int             WDW       = $clog2(TIMEOUT + 1);
  localparam logic [5:0]     C_WS      = 6'(WS);
  localparam logic [WDW-1:0] C_WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [WDW-1:0] C_WD_MAX  = WDW'(TIMEOUT);

  logic [SYNC-1:0] r_bclk_sync, r_lrck_sync, r_dat_sync;
  logic            r_bclk_prev, r_lrck_last, r_left_ok;
  logic [5:0]      r_cnt;
  logic [WS-1:0]   r_sh_l, r_sh_r, r_hold_l;
  logic [WDW-1:0]  r_wd;
  state_t          r_state, w_state_next;

  logic          w_bclk, w_lrck, w_dat;
  logic          w_bit, w_bnd, w_take, w_slot_full, w_to;
  logic          w_latch_l, w_frame_end, w_good, w_bad;
  logic [WS-1:0] w_sh_l_next, w_sh_r_next;

  // All three inputs share one synchroniser depth so LRCK/DAT line up with BCLK.
  always_ff @(posedge iCLK_50) begin
    if (!iRST_N) begin
      r_bclk_sync <= '0;
      r_lrck_sync <= '0;
      r_dat_sync  <= '0;
    end else begin
      r_bclk_sync <= {r_bclk_sync[SYNC-2:0], iAUD_BCLK};
      r_lrck_sync <= {r_lrck_sync[SYNC-2:0], iAUD_ADCLRCK};
      r_dat_sync  <= {r_dat_sync[SYNC-2:0], iAUD_ADCDAT};
    end
  end

  assign w_bclk = r_bclk_sync[SYNC-1];
  assign w_lrck = r_lrck_sync[SYNC-1];
  assign w_dat  = r_dat_sync[SYNC-1];

  assign w_bit       = w_bclk & ~r_bclk_prev;
  assign w_bnd       = w_bit & (w_lrck != r_lrck_last);
  assign w_slot_full = (r_cnt >= C_WS);
  assign w_to        = !w_bit && (r_wd == C_WD_LAST);

  // One-bit delay: the bit sampled at an event belongs to the slot of the
  // previous event, indexed by the count before this event. So the boundary
  // bit is the ending slot's last bit and never enters the new slot.
  assign w_take = w_bit && (r_cnt != '0) && (r_cnt <= C_WS);

  always_comb begin
    w_sh_l_next = r_sh_l;
    w_sh_r_next = r_sh_r;
    if (w_take) begin
      if (r_lrck_last) w_sh_r_next = {r_sh_r[WS-2:0], w_dat};
      else             w_sh_l_next = {r_sh_l[WS-2:0], w_dat};
    end
  end

  // FSM: state register
  always_ff @(posedge iCLK_50) begin
    if (!iRST_N) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    if (w_to) begin
      w_state_next = S_IDLE;
    end else if (w_bnd) begin
      case (r_state)
        S_IDLE:  if (!w_lrck) w_state_next = S_LEFT;
        S_LEFT:  if (w_lrck)  w_state_next = S_RIGHT;
        S_RIGHT: if (!w_lrck) w_state_next = S_LEFT;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    w_latch_l   = 1'b0;
    w_frame_end = 1'b0;
    case (r_state)
      S_LEFT:  w_latch_l   = w_bnd && w_lrck;
      S_RIGHT: w_frame_end = w_bnd && !w_lrck;
      default: ;
    endcase
    w_good = w_frame_end && w_slot_full && r_left_ok;
    w_bad  = w_frame_end && !(w_slot_full && r_left_ok);
  end

  always_ff @(posedge iCLK_50) begin
    if (!iRST_N) begin
      r_bclk_prev <= 1'b0;
      r_lrck_last <= 1'b0;
      r_cnt       <= '0;
      r_sh_l      <= '0;
      r_sh_r      <= '0;
      r_hold_l    <= '0;
      r_left_ok   <= 1'b0;
      r_wd        <= '0;
      oL          <= '0;
      oR          <= '0;
      oValid      <= 1'b0;
      oLocked     <= 1'b0;
      oErrCnt     <= '0;
    end else begin
      r_bclk_prev <= w_bclk;
      r_sh_l      <= w_sh_l_next;
      r_sh_r      <= w_sh_r_next;
      if (w_bit) begin
        r_lrck_last <= w_lrck;
        if (w_bnd)               r_cnt <= 6'd1;
        else if (r_cnt != '1)    r_cnt <= r_cnt + 6'd1;
        r_wd <= '0;
      end else if (r_wd != C_WD_MAX) begin
        r_wd <= r_wd + 1'b1;
      end
      if (w_latch_l) begin
        r_hold_l  <= w_sh_l_next;
        r_left_ok <= w_slot_full;
      end
      oValid <= w_good;
      if (w_good) begin
        oL      <= r_hold_l;
        oR      <= w_sh_r_next;
        oLocked <= 1'b1;
      end
      if (w_bad && (oErrCnt != 8'hFF)) oErrCnt <= oErrCnt + 8'd1;
      if (w_to) oLocked <= 1'b0;
    end
  end

endmodule
